// File: rtl/reflet_ram_pkg.sv
// Shared types and helpers for the banked reflet RAM.
// Size encodings, sequencer states and byte-to-bank address mapping.
// All helpers are constant-foldable for a power-of-two lane count.
package reflet_ram_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic {CLEAR, IDLE} state_t;

   // Number of byte lanes (and banks) for a given word width.
   function automatic int lanes(input int word_size);
      return word_size / 8;
   endfunction

   // Bank holding a byte address.
   function automatic int bank_of(input int byte_addr, input int n);
      return byte_addr % n;
   endfunction

   // Row inside its bank of a byte address.
   function automatic int row_of(input int byte_addr, input int n);
      return byte_addr / n;
   endfunction

   // Bytes touched by an access: 2**size_sel, clamped to the lane count.
   function automatic logic [3:0] access_bytes(input logic [1:0] sz, input int n);
      logic [3:0] b;
      case (sz)
         SZ_BYTE:  b = 4'd1;
         SZ_HALF:  b = 4'd2;
         SZ_WORD:  b = 4'd4;
         SZ_DWORD: b = 4'd8;
         default:  b = 4'd1;
      endcase
      if (int'(b) > n) b = 4'(n);
      return b;
   endfunction

endpackage

// File: rtl/reflet_ram_bank.sv
// One 8-bit synchronous RAM bank.
// Write and read both complete on the rising edge; dout changes only on re.
// Rows beyond the bank depth are ignored on write and read back as zero.
module reflet_ram_bank #(
   parameter int rows  = 256,
   parameter int row_w = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [row_w-1:0] row,
   input  logic [7:0]       din,
   output logic [7:0]       dout
);

   localparam int IW = (rows > 1) ? $clog2(rows) : 1;

   logic [7:0] mem [rows];
   logic       in_range;

   assign in_range = int'(row) < rows;

   // Storage write and registered read; dout holds between reads.
   always_ff @(posedge clk) begin
      if (we && in_range) mem[IW'(row)] <= din;
      if (re) dout <= in_range ? mem[IW'(row)] : 8'h00;
   end

endmodule

// File: rtl/reflet_ram_banked.sv
// Byte-addressable RAM of N byte banks with unaligned byte/half/word/dword access.
// Read latency 1 cycle (data_out/data_valid registered), writes visible next cycle.
// No back-pressure on read data; ready is low while clearing or when enable is low.
module reflet_ram_banked
   import reflet_ram_pkg::*;
#(
   parameter int wordSize  = 16,
   parameter int addrSize  = 9,
   parameter int size      = 2**addrSize,
   parameter int resetable = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                req,
   input  logic                write_en,
   input  logic [1:0]          size_sel,
   input  logic [addrSize-1:0] addr,
   input  logic [wordSize-1:0] data_in,
   output logic                ready,
   output logic [wordSize-1:0] data_out,
   output logic                data_valid
);

   localparam int N     = lanes(wordSize);
   localparam int LG    = $clog2(N);
   localparam int ROWS  = (size + N - 1) / N;
   localparam int ROW_W = (addrSize > LG) ? addrSize - LG : 1;

   state_t           state, state_nxt;
   logic [ROW_W-1:0] clr_row;
   logic             armed;       // holds ready low for the first cycle after reset release
   logic             accept;
   logic [3:0]       nbytes;
   logic [N-1:0]     lane_ok;     // lane inside access size and inside memory
   logic [N-1:0]     rd_mask;     // lane mask of the last accepted read
   logic [2:0]       rd_off;      // bank of lane 0 for the last accepted read
   logic [N-1:0]     bank_we, bank_re;
   logic [ROW_W-1:0] bank_row  [N];
   logic [7:0]       bank_din  [N];
   logic [7:0]       bank_dout [N];

   assign ready  = (state == IDLE) && enable && armed;
   assign accept = req && ready;
   assign nbytes = access_bytes(size_sel, N);

   // Sequencer state, clear counter and post-reset arming.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= (resetable != 0) ? CLEAR : IDLE;
         clr_row <= '0;
         armed   <= 1'b0;
      end else begin
         armed <= 1'b1;
         state <= state_nxt;
         if (state == CLEAR && enable) clr_row <= clr_row + ROW_W'(1);
      end
   end

   // Leave CLEAR once the last row has been zeroed.
   always_comb begin
      state_nxt = state;
      if (state == CLEAR && enable && clr_row == ROW_W'(ROWS - 1)) state_nxt = IDLE;
   end

   // Per-lane validity: within the requested size and below the memory top.
   always_comb begin
      int la;
      la      = 0;
      lane_ok = '0;
      for (int k = 0; k < N; k++) begin
         la         = int'(addr) + k;
         lane_ok[k] = (k < int'(nbytes)) && (la < size);
      end
   end

   // Route each lane to its bank; unaligned accesses span rows r and r+1.
   always_comb begin
      int la;
      la = 0;
      for (int b = 0; b < N; b++) begin
         bank_we[b]  = 1'b0;
         bank_re[b]  = 1'b0;
         bank_row[b] = clr_row;
         bank_din[b] = 8'h00;
      end
      if (state == CLEAR) begin
         bank_we = {N{enable}};
      end else if (accept) begin
         for (int b = 0; b < N; b++) begin
            for (int k = 0; k < N; k++) begin
               la = int'(addr) + k;
               if (bank_of(la, N) == b) begin
                  bank_row[b] = ROW_W'(row_of(la, N));
                  bank_din[b] = data_in[8*k +: 8];
                  bank_we[b]  = write_en && lane_ok[k];
                  bank_re[b]  = !write_en;
               end
            end
         end
      end
   end

   // Capture read lane mask and rotation; reset drops any outstanding read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_valid <= 1'b0;
         rd_mask    <= '0;
         rd_off     <= '0;
      end else begin
         data_valid <= accept && !write_en;
         if (accept && !write_en) begin
            rd_mask <= lane_ok;
            rd_off  <= 3'(bank_of(int'(addr), N));
         end
      end
   end

   // Rotate bank outputs back into lane order and zero masked lanes.
   always_comb begin
      int idx;
      idx      = 0;
      data_out = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(rd_off) + k) % N;
         if (rd_mask[k]) data_out[8*k +: 8] = bank_dout[idx];
      end
   end

   for (genvar b = 0; b < N; b++) begin : g_bank
      reflet_ram_bank #(
         .rows  (ROWS),
         .row_w (ROW_W)
      ) u_bank (
         .clk  (clk),
         .we   (bank_we[b]),
         .re   (bank_re[b]),
         .row  (bank_row[b]),
         .din  (bank_din[b]),
         .dout (bank_dout[b])
      );
   end

endmodule

// File: tb/tb_reflet_ram_banked.sv
// Bench for reflet_ram_banked: 32-bit clearing instance and 64-bit non-clearing instance.
// Reads push expected data and response cycle into a scoreboard queue; monitors pop on data_valid.
// Scenarios cover clear timing, unaligned access, byte merge, top-of-memory drop, enable and reset.
module tb_reflet_ram_banked;
   import reflet_ram_pkg::*;

   typedef struct {
      logic [63:0] d;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q32[$];
   exp_t q64[$];

   logic        rst32, en32, req32, we32, rdy32, vld32;
   logic [1:0]  sz32;
   logic [5:0]  addr32;
   logic [31:0] din32, dout32;

   logic        rst64, en64, req64, we64, rdy64, vld64;
   logic [1:0]  sz64;
   logic [5:0]  addr64;
   logic [63:0] din64, dout64;

   reflet_ram_banked #(.wordSize(32), .addrSize(6), .size(64), .resetable(1)) dut32 (
      .clk(clk), .reset(rst32), .enable(en32), .req(req32), .write_en(we32),
      .size_sel(sz32), .addr(addr32), .data_in(din32),
      .ready(rdy32), .data_out(dout32), .data_valid(vld32)
   );

   reflet_ram_banked #(.wordSize(64), .addrSize(6), .size(64), .resetable(0)) dut64 (
      .clk(clk), .reset(rst64), .enable(en64), .req(req64), .write_en(we64),
      .size_sel(sz64), .addr(addr64), .data_in(din64),
      .ready(rdy64), .data_out(dout64), .data_valid(vld64)
   );

   task automatic wr32(input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
      req32 = 1'b1; we32 = 1'b1; addr32 = a; sz32 = s; din32 = d;
      @(negedge clk);
      req32 = 1'b0; we32 = 1'b0;
   endtask

   task automatic rd32(input logic [5:0] a, input logic [1:0] s, input logic [31:0] e);
      req32 = 1'b1; we32 = 1'b0; addr32 = a; sz32 = s;
      q32.push_back('{d: {32'h0, e}, cyc: cyc + 1});
      @(negedge clk);
      req32 = 1'b0;
   endtask

   task automatic wr64(input logic [5:0] a, input logic [1:0] s, input logic [63:0] d);
      req64 = 1'b1; we64 = 1'b1; addr64 = a; sz64 = s; din64 = d;
      @(negedge clk);
      req64 = 1'b0; we64 = 1'b0;
   endtask

   task automatic rd64(input logic [5:0] a, input logic [1:0] s, input logic [63:0] e);
      req64 = 1'b1; we64 = 1'b0; addr64 = a; sz64 = s;
      q64.push_back('{d: e, cyc: cyc + 1});
      @(negedge clk);
      req64 = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      @(negedge clk);
      n_checks++;
      if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy32); end
      n_checks++;
      if (vld32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld32); end
      n_checks++;
      if (dout32 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dout32); end
      rst32 = 1'b0;
      n = 0;
      while (rdy32 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if (n != 16) begin n_fail++; $display("FAIL clear_cycles: got %0d want 16", n); end
      for (int i = 0; i < 16; i++) rd32(6'(i * 4), SZ_WORD, 32'h0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_unaligned();
      wr32(6'h05, SZ_DWORD, 32'h44332211);
      rd32(6'h04, SZ_DWORD, 32'h33221100);
      rd32(6'h05, SZ_DWORD, 32'h44332211);
      rd32(6'h08, SZ_WORD,  32'h00000044);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_byte_merge();
      wr32(6'h04, SZ_WORD, 32'hDDCCBBAA);
      wr32(6'h07, SZ_BYTE, 32'h000000AB);
      rd32(6'h04, SZ_WORD, 32'hABCCBBAA);
      rd32(6'h06, SZ_HALF, 32'h0000ABCC);
      rd32(6'h05, SZ_BYTE, 32'h000000BB);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_top_boundary();
      wr32(6'h3E, SZ_WORD, 32'h11223344);
      rd32(6'h3E, SZ_WORD, 32'h00003344);
      rd32(6'h00, SZ_WORD, 32'h00000000);
      rd32(6'h3C, SZ_WORD, 32'h33440000);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_enable();
      en32 = 1'b0;
      #1;
      n_checks++;
      if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL enable_low_ready: got %b want 0", rdy32); end
      req32 = 1'b1; we32 = 1'b0; addr32 = 6'h04; sz32 = SZ_WORD;
      repeat (2) @(negedge clk);
      n_checks++;
      if (vld32 !== 1'b0) begin n_fail++; $display("FAIL enable_low_valid: got %b want 0", vld32); end
      req32 = 1'b0;
      en32  = 1'b1;
      #1;
      n_checks++;
      if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL enable_high_ready: got %b want 1", rdy32); end
      rd32(6'h04, SZ_WORD, 32'hABCCBBAA);
      en32 = 1'b0;
      @(negedge clk);
      en32 = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_clear();
      int n;
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL mid_clear_ready: got %b want 0", rdy32); end
      rst32 = 1'b1;
      #1;
      n_checks++;
      if (vld32 !== 1'b0) begin n_fail++; $display("FAIL mid_clear_valid: got %b want 0", vld32); end
      @(negedge clk);
      rst32 = 1'b0;
      n = 0;
      while (rdy32 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if (n != 16) begin n_fail++; $display("FAIL reclear_cycles: got %0d want 16", n); end
      for (int i = 0; i < 16; i++) rd32(6'(i * 4), SZ_WORD, 32'h0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clear_pause();
      int n;
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      repeat (4) @(negedge clk);
      en32 = 1'b0;
      repeat (3) @(negedge clk);
      en32 = 1'b1;
      n = 7;
      while (rdy32 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if (n != 19) begin n_fail++; $display("FAIL clear_pause_cycles: got %0d want 19", n); end
   endtask

   task automatic test_back_to_back64();
      rst64 = 1'b0;
      #1;
      n_checks++;
      if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL r64_ready_release: got %b want 0", rdy64); end
      @(negedge clk);
      n_checks++;
      if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL r64_ready_next: got %b want 1", rdy64); end
      wr64(6'h03, SZ_DWORD, 64'h0123456789ABCDEF);
      rd64(6'h03, SZ_DWORD, 64'h0123456789ABCDEF);
      rd64(6'h03, SZ_HALF,  64'h000000000000CDEF);
      wr64(6'h0B, SZ_BYTE,  64'h000000000000005A);
      rd64(6'h0A, SZ_HALF,  64'h0000000000005A01);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst32 = 1'b0; en32 = 1'b1; req32 = 1'b0; we32 = 1'b0; sz32 = 2'd0; addr32 = '0; din32 = '0;
      rst64 = 1'b0; en64 = 1'b1; req64 = 1'b0; we64 = 1'b0; sz64 = 2'd0; addr64 = '0; din64 = '0;
      #2;
      rst32 = 1'b1;
      rst64 = 1'b1;

      fork
         begin : mon32
            exp_t e;
            forever begin
               @(negedge clk);
               if (vld32 === 1'b1) begin
                  n_checks++;
                  if (q32.size() == 0) begin
                     n_fail++;
                     $display("FAIL spurious_valid32: got valid at cycle %0d want none", cyc);
                  end else begin
                     e = q32.pop_front();
                     if (dout32 !== e.d[31:0] || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL read32: got %h at cycle %0d want %h at cycle %0d",
                                 dout32, cyc, e.d[31:0], e.cyc);
                     end
                  end
               end
               while (q32.size() > 0 && q32[0].cyc < cyc) begin
                  e = q32.pop_front();
                  n_checks++;
                  n_fail++;
                  $display("FAIL missing_valid32: none by cycle %0d want %h at cycle %0d", cyc, e.d[31:0], e.cyc);
               end
            end
         end
         begin : mon64
            exp_t e;
            forever begin
               @(negedge clk);
               if (vld64 === 1'b1) begin
                  n_checks++;
                  if (q64.size() == 0) begin
                     n_fail++;
                     $display("FAIL spurious_valid64: got valid at cycle %0d want none", cyc);
                  end else begin
                     e = q64.pop_front();
                     if (dout64 !== e.d || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL read64: got %h at cycle %0d want %h at cycle %0d",
                                 dout64, cyc, e.d, e.cyc);
                     end
                  end
               end
               while (q64.size() > 0 && q64[0].cyc < cyc) begin
                  e = q64.pop_front();
                  n_checks++;
                  n_fail++;
                  $display("FAIL missing_valid64: none by cycle %0d want %h at cycle %0d", cyc, e.d, e.cyc);
               end
            end
         end
      join_none

      test_reset();
      test_unaligned();
      test_byte_merge();
      test_top_boundary();
      test_enable();
      test_reset_mid_clear();
      test_clear_pause();
      test_back_to_back64();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
